// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared signal-lamp and phase encodings for the intersection controller.
// Used by the phase scheduler and the per-approach traffic_signal lamp driver.
package traffic_pkg;

  localparam int N_APPR = 4;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } sig_t;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_t;

endpackage

// File: rtl/intersection_phase_scheduler_rr_next_pick.sv
// Combinational round-robin search: first set pending bit at start, start+1, ...
// wrapping modulo four.
module rr_next_pick (
  input  logic [3:0] pending,
  input  logic [1:0] start,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] w_idx;

  // Walk from the farthest offset back to the nearest so the nearest set bit wins.
  always_comb begin
    winner = start;
    valid  = 1'b0;
    w_idx  = '0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = start + 2'(k);
      if (pending[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Actuated four-approach phase scheduler: one right-of-way holder at a time,
// yellow and all-red clearance between grants, emergency preempt override.
module intersection_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_APPR-1:0]     req,
  input  logic                  preempt,
  input  logic [1:0]            preempt_dir,
  output logic [2*N_APPR-1:0]   signal,
  output logic [1:0]            active_dir,
  output logic [1:0]            phase,
  output logic                  preempt_ack
);

  import traffic_pkg::*;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_TOP = max_int(max_int(GREEN_MAX, YELLOW_T), ALLRED_T);
  localparam int CNT_W   = $clog2(CNT_TOP) + 1;

  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_TOP - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);

  phase_t              r_phase;
  phase_t              w_phase_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_active;
  logic [1:0]          w_active_nxt;
  logic [N_APPR-1:0]   r_pending;
  logic [N_APPR-1:0]   w_pending_nxt;
  logic [N_APPR-1:0]   w_grant_mask;
  logic [1:0]          w_rr_winner;
  logic                w_rr_valid;
  logic [1:0]          w_target;
  logic                w_grant;
  logic                w_other;
  logic                w_pre_other;
  sig_t                w_lamp;

  rr_next_pick u_rr (
    .pending (r_pending),
    .start   (r_active + 2'd1),
    .winner  (w_rr_winner),
    .valid   (w_rr_valid)
  );

  assign w_other     = |(r_pending & ~(N_APPR'(1) << r_active));
  assign w_pre_other = preempt && (preempt_dir != r_active);
  assign w_target    = preempt ? preempt_dir : w_rr_winner;

  always_comb begin
    w_phase_nxt  = r_phase;
    w_active_nxt = r_active;
    w_grant      = 1'b0;
    case (r_phase)
      PH_ALL_RED: begin
        if ((r_cnt >= ALLRED_LAST) && (w_rr_valid || preempt)) begin
          w_phase_nxt  = PH_GREEN;
          w_active_nxt = w_target;
          w_grant      = 1'b1;
        end
      end
      PH_GREEN: begin
        // Preempt toward another approach ends green regardless of the minimum.
        if (w_pre_other ||
            (!preempt && w_other &&
             (((r_cnt >= GMIN_LAST) && !req[r_active]) || (r_cnt == GMAX_LAST)))) begin
          w_phase_nxt = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (r_cnt == YEL_LAST) begin
          w_phase_nxt = PH_ALL_RED;
        end
      end
      default: w_phase_nxt = PH_ALL_RED;
    endcase
  end

  // Clearing on the grant edge wins over a detector hit in the same cycle.
  assign w_grant_mask  = w_grant ? (N_APPR'(1) << w_target) : '0;
  assign w_pending_nxt = (r_pending | req) & ~w_grant_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= PH_ALL_RED;
      r_cnt     <= '0;
      r_active  <= '0;
      r_pending <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
      if (w_phase_nxt != r_phase) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_lamp = RED;
    if (r_phase == PH_GREEN) begin
      w_lamp = GREEN;
    end else if (r_phase == PH_YELLOW) begin
      w_lamp = YELLOW;
    end
  end

  always_comb begin
    signal = '0;
    for (int i = 0; i < N_APPR; i++) begin
      if (r_active == 2'(i)) begin
        signal[2*i +: 2] = w_lamp;
      end
    end
  end

  assign active_dir  = r_active;
  assign phase       = r_phase;
  assign preempt_ack = preempt && (r_phase == PH_GREEN) && (r_active == preempt_dir);

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: rule-level reference model compared every
// cycle, plus directed scenarios with hand-derived phase durations and grants.
module tb_intersection_phase_scheduler;

  localparam int GREEN_MIN = 8;
  localparam int GREEN_MAX = 20;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       preempt = 1'b0;
  logic [1:0] preempt_dir = 2'd0;
  logic [7:0] signal;
  logic [1:0] active_dir;
  logic [1:0] phase;
  logic       preempt_ack;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Reference state: phase 0/1/2, unsaturated time in phase, holder, demand set.
  int         m_phase = 0;
  int         m_t     = 0;
  int         m_act   = 0;
  logic [3:0] m_pend  = 4'b0000;

  intersection_phase_scheduler #(
    .N_APPR    (4),
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .signal      (signal),
    .active_dir  (active_dir),
    .phase       (phase),
    .preempt_ack (preempt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advanced from the rules: who may be granted, when green must end.
  always @(posedge clk) begin
    int nxt;
    int tgt;
    int other;
    bit grant;
    if (rst) begin
      m_phase = 0; m_t = 0; m_act = 0; m_pend = 4'b0000;
    end else begin
      nxt = m_phase; tgt = m_act; grant = 1'b0; other = 0;
      for (int d = 0; d < 4; d++) if (d != m_act && m_pend[d]) other = 1;
      if (m_phase == 0) begin
        if (m_t >= ALLRED_T - 1 && (m_pend != 4'b0000 || preempt)) begin
          if (preempt) tgt = int'(preempt_dir);
          else for (int k = 4; k >= 1; k--) if (m_pend[(m_act + k) % 4]) tgt = (m_act + k) % 4;
          nxt = 1; grant = 1'b1;
        end
      end else if (m_phase == 1) begin
        if ((preempt && int'(preempt_dir) != m_act) ||
            (!preempt && other == 1 && m_t >= GREEN_MIN - 1 && !req[m_act]) ||
            (!preempt && other == 1 && m_t >= GREEN_MAX - 1))
          nxt = 2;
      end else begin
        if (m_t == YELLOW_T - 1) nxt = 0;
      end
      m_pend = m_pend | req;
      if (grant) m_pend[tgt] = 1'b0;
      if (nxt != m_phase) begin
        m_phase = nxt; m_t = 0;
        if (grant) m_act = tgt;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    int exp_sig;
    int exp_ack;
    if (armed) begin
      exp_sig = (m_phase == 0) ? 0 : (m_phase << (2 * m_act));
      exp_ack = (preempt && m_phase == 1 && m_act == int'(preempt_dir)) ? 1 : 0;
      chk("model_signal", int'(signal), exp_sig);
      chk("model_phase", int'(phase), m_phase);
      chk("model_active_dir", int'(active_dir), m_act);
      chk("model_preempt_ack", int'(preempt_ack), exp_ack);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_phase(input int p, output int n);
    n = 0;
    while (int'(phase) == p && n < 300) begin
      n++;
      tick(1);
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL phase_%0d_timeout: got %0d cycles limit 300", p, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset held three cycles
    tick(1);
    armed = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset_signal", int'(signal), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_active", int'(active_dir), 0);
    chk("reset_ack", int'(preempt_ack), 0);
    tick(50);
    chk("idle_signal", int'(signal), 0);
    chk("idle_phase", int'(phase), 0);

    // Single request on approach 2: latch edge, then grant edge
    req = 4'b0100;
    tick(1);
    chk("single_latch_phase", int'(phase), 0);
    req = 4'b0000;
    tick(1);
    chk("single_grant_phase", int'(phase), 1);
    chk("single_grant_active", int'(active_dir), 2);
    chk("single_grant_signal", int'(signal), 8'h10);
    tick(100);
    chk("single_hold_phase", int'(phase), 1);
    chk("single_hold_signal", int'(signal), 8'h10);

    // Max-out: approach 0 holds req, approach 1 arrives at green cnt 3
    do_reset();
    req = 4'b0001;
    tick(2);
    chk("maxout_grant_active", int'(active_dir), 0);
    chk("maxout_grant_phase", int'(phase), 1);
    tick(3);
    req = 4'b0011;
    tick(1);
    req = 4'b0001;
    count_phase(1, n);
    chk("maxout_green_len", n + 4, 20);
    count_phase(2, n);
    chk("maxout_yellow_len", n, 3);
    count_phase(0, n);
    chk("maxout_allred_len", n, 2);
    chk("maxout_next_active", int'(active_dir), 1);
    chk("maxout_next_signal", int'(signal), 8'h04);
    req = 4'b0000;

    // Gap-out: req[0] dropped at cnt 2, approach 3 waiting
    do_reset();
    req = 4'b0001;
    tick(2);
    tick(2);
    req = 4'b1000;
    tick(1);
    req = 4'b0000;
    count_phase(1, n);
    chk("gapout_green_len", n + 3, 8);
    count_phase(2, n);
    chk("gapout_yellow_len", n, 3);
    count_phase(0, n);
    chk("gapout_allred_len", n, 2);
    chk("gapout_next_active", int'(active_dir), 3);
    count_phase(1, n);
    chk("gapout_second_green_len", n, 8);
    count_phase(2, n);
    count_phase(0, n);
    chk("gapout_following_active", int'(active_dir), 0);

    // Round-robin from approach 1 with pending 1001
    do_reset();
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    tick(1);
    chk("rr_first_active", int'(active_dir), 1);
    req = 4'b1001;
    tick(1);
    req = 4'b0000;
    count_phase(1, n);
    chk("rr_green_len", n + 1, 8);
    count_phase(2, n);
    count_phase(0, n);
    chk("rr_next_active", int'(active_dir), 3);
    count_phase(1, n);
    count_phase(2, n);
    count_phase(0, n);
    chk("rr_following_active", int'(active_dir), 0);

    // Preempt toward approach 2 at green cnt 1 of approach 0, pending[1] waiting
    do_reset();
    req = 4'b0001;
    tick(2);
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    preempt = 1'b1;
    preempt_dir = 2'd2;
    tick(1);
    chk("preempt_yellow_phase", int'(phase), 2);
    chk("preempt_yellow_signal", int'(signal), 8'h02);
    count_phase(2, n);
    chk("preempt_yellow_len", n, 3);
    count_phase(0, n);
    chk("preempt_allred_len", n, 2);
    chk("preempt_green_active", int'(active_dir), 2);
    chk("preempt_green_phase", int'(phase), 1);
    chk("preempt_ack_high", int'(preempt_ack), 1);
    tick(30);
    chk("preempt_hold_active", int'(active_dir), 2);
    chk("preempt_hold_ack", int'(preempt_ack), 1);
    preempt = 1'b0;
    tick(1);
    chk("release_yellow_phase", int'(phase), 2);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("midreset_signal", int'(signal), 0);
    chk("midreset_phase", int'(phase), 0);
    chk("midreset_active", int'(active_dir), 0);
    rst = 1'b0;
    tick(20);
    chk("after_reset_no_demand", int'(phase), 0);

    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
